// File: rtl/m26_tx_core.sv
// Two-line framed serial transmitter: header, frame counter, length, data, trailer, zero padding.
// Optional underflow counter enabled by defining M26_TX_UNDERFLOW_CNT_EN.
module m26_tx_core #(
    parameter int unsigned FRAME_WORDS = 576,
    parameter logic [15:0] TRAILER     = 16'hAAAA
) (
    input  logic        CLK_TX,
    input  logic        RST,
    input  logic        EN,
    input  logic [9:0]  DATA_LEN,
    input  logic [31:0] DATA_IN,
    input  logic        DATA_VALID,
    output logic        DATA_READY,
    output logic        MKD_TX,
    output logic [1:0]  DATA_TX,
    output logic        BUSY,
    output logic [31:0] FRAME_CNT,
    output logic [7:0]  UNDERFLOW_CNT
);

    localparam int unsigned WW      = $clog2(FRAME_WORDS);
    localparam int unsigned MAX_LEN = FRAME_WORDS - 4;
    localparam logic [WW-1:0] LAST_WORD = WW'(FRAME_WORDS - 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_HEADER, ST_FCNT, ST_LEN, ST_DATA, ST_TRAILER, ST_PAD
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    bit_q, bit_d;
    logic [WW-1:0] word_q, word_d;
    logic [9:0]    len_q, len_d;
    logic [9:0]    rem_q, rem_d;
    logic [15:0]   shift_q [2];
    logic [15:0]   shift_d [2];
    logic [31:0]   frame_cnt_q, frame_cnt_d;
    logic          mkd_q, mkd_d;
    logic          busy_q, busy_d;
    logic          ld_q, ld_d;
    logic          load_now;
    logic          start;
    logic [9:0]    len_clamp;

    assign len_clamp = (32'(DATA_LEN) > MAX_LEN) ? 10'(MAX_LEN) : DATA_LEN;

    always_comb begin
        state_d     = state_q;
        bit_d       = bit_q;
        word_d      = word_q;
        len_d       = len_q;
        rem_d       = rem_q;
        frame_cnt_d = frame_cnt_q;
        shift_d[0]  = shift_q[0] << 1;
        shift_d[1]  = shift_q[1] << 1;
        load_now    = 1'b0;
        start       = 1'b0;
        if (state_q == ST_IDLE) begin
            shift_d[0] = '0;
            shift_d[1] = '0;
            start      = EN;
        end else if (bit_q != 4'd15) begin
            bit_d = bit_q + 4'd1;
        end else begin
            bit_d  = 4'd0;
            word_d = word_q + WW'(1);
            case (state_q)
                ST_HEADER: begin
                    state_d    = ST_FCNT;
                    shift_d[0] = frame_cnt_q[15:0];
                    shift_d[1] = frame_cnt_q[31:16];
                end
                ST_FCNT: begin
                    state_d    = ST_LEN;
                    shift_d[0] = {6'd0, len_q};
                    shift_d[1] = {6'd0, len_q};
                end
                ST_LEN, ST_DATA: begin
                    if ((state_q == ST_LEN) ? (len_q == 10'd0) : (rem_q == 10'd0)) begin
                        state_d    = ST_TRAILER;
                        shift_d[0] = TRAILER;
                        shift_d[1] = TRAILER;
                    end else begin
                        state_d  = ST_DATA;
                        rem_d    = ((state_q == ST_LEN) ? len_q : rem_q) - 10'd1;
                        load_now = 1'b1;
                    end
                end
                ST_TRAILER, ST_PAD: begin
                    shift_d[0] = '0;
                    shift_d[1] = '0;
                    if (word_q == LAST_WORD) begin
                        frame_cnt_d = frame_cnt_q + 32'd1;
                        word_d      = '0;
                        state_d     = ST_IDLE;
                        start       = EN;
                    end else begin
                        state_d = ST_PAD;
                    end
                end
                default: ;
            endcase
        end
        // A missing word pair is replaced by zeros so the frame length never changes.
        if (load_now) begin
            shift_d[0] = DATA_VALID ? DATA_IN[15:0]  : 16'h0000;
            shift_d[1] = DATA_VALID ? DATA_IN[31:16] : 16'h0000;
        end
        if (start) begin
            state_d    = ST_HEADER;
            bit_d      = 4'd0;
            word_d     = '0;
            len_d      = len_clamp;
            shift_d[0] = 16'h5555;
            shift_d[1] = 16'h5555;
        end
        mkd_d  = (state_d == ST_HEADER) && (bit_d < 4'd4);
        busy_d = (state_d != ST_IDLE);
        ld_d   = (bit_d == 4'd15) &&
                 (((state_d == ST_LEN) && (len_d != 10'd0)) ||
                  ((state_d == ST_DATA) && (rem_d != 10'd0)));
    end

    always_ff @(posedge CLK_TX) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            bit_q       <= '0;
            word_q      <= '0;
            len_q       <= '0;
            rem_q       <= '0;
            shift_q[0]  <= '0;
            shift_q[1]  <= '0;
            frame_cnt_q <= '0;
            mkd_q       <= 1'b0;
            busy_q      <= 1'b0;
            ld_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_q       <= bit_d;
            word_q      <= word_d;
            len_q       <= len_d;
            rem_q       <= rem_d;
            shift_q[0]  <= shift_d[0];
            shift_q[1]  <= shift_d[1];
            frame_cnt_q <= frame_cnt_d;
            mkd_q       <= mkd_d;
            busy_q      <= busy_d;
            ld_q        <= ld_d;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_line
            assign DATA_TX[gi] = shift_q[gi][15];
        end
    endgenerate

    // ld_q flags the load cycle; the handshake itself follows DATA_VALID in that cycle.
    assign DATA_READY = ld_q & DATA_VALID & ~RST;
    assign MKD_TX     = mkd_q;
    assign BUSY       = busy_q;
    assign FRAME_CNT  = frame_cnt_q;

`ifdef M26_TX_UNDERFLOW_CNT_EN
    logic [7:0] uflow_q, uflow_d;

    always_comb begin
        uflow_d = uflow_q;
        if (load_now && !DATA_VALID && (uflow_q != 8'hFF))
            uflow_d = uflow_q + 8'd1;
    end

    always_ff @(posedge CLK_TX) begin
        if (RST) uflow_q <= '0;
        else     uflow_q <= uflow_d;
    end

    assign UNDERFLOW_CNT = uflow_q;
`else
    assign UNDERFLOW_CNT = 8'h00;
`endif

endmodule
